// File: rtl/nonogram_pkg.sv
// Shared types and default sizing for the nonogram line solver.
package nonogram_pkg;

    localparam int unsigned DefaultSize       = 3;
    localparam int unsigned DefaultMaxOptions = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        READ,
        ISSUE,
        WAIT,
        FINISH
    } seq_state_t;

    // Field widths follow DefaultSize; instances must use SIZE == DefaultSize.
    typedef struct packed {
        logic [DefaultSize-1:0] assigned;
        logic [DefaultSize-1:0] known;
        logic                   contradict;
        logic                   changed;
    } line_result_t;

endpackage

// File: rtl/option_accumulator.sv
// Folds surviving options into AND/OR masks and a survivor count, and merges them
// with the latched line state into the deduced result.
module option_accumulator
    import nonogram_pkg::*;
#(
    parameter int unsigned SIZE  = DefaultSize,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             acc_en_i,
    input  logic [SIZE-1:0]  option_i,
    input  logic [SIZE-1:0]  assigned_i,
    input  logic [SIZE-1:0]  known_i,
    output logic [CNT_W-1:0] survivors_o,
    output logic             saturated_o,
    output line_result_t     result_o
);

    logic [SIZE-1:0]  and_q, and_d;
    logic [SIZE-1:0]  or_q, or_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]  newly;
    logic [SIZE-1:0]  known_m;

    // Next-state: clear on pass start, fold in an option on each survivor.
    always_comb begin
        and_d = and_q;
        or_d  = or_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            and_d = '1;
            or_d  = '0;
            cnt_d = '0;
        end else if (acc_en_i) begin
            and_d = and_q & option_i;
            or_d  = or_q | option_i;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Accumulator state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            and_q <= '1;
            or_q  <= '0;
            cnt_q <= '0;
        end else begin
            and_q <= and_d;
            or_q  <= or_d;
            cnt_q <= cnt_d;
        end
    end

    // Merge: an unknown cell is deduced when every survivor agrees on its value.
    always_comb begin
        newly       = ~known_i & (and_q | ~or_q);
        known_m     = known_i | newly;
        // True when folding option_i would leave no unknown cell with a unanimous value.
        saturated_o = ((((and_q & option_i) | ~(or_q | option_i)) & ~known_i) == '0);
        result_o    = '0;
        if (cnt_q == '0) begin
            result_o.assigned   = assigned_i;
            result_o.known      = known_i;
            result_o.contradict = 1'b1;
            result_o.changed    = 1'b0;
        end else begin
            result_o.assigned   = (assigned_i & known_i) | (and_q & newly);
            result_o.known      = known_m;
            result_o.contradict = 1'b0;
            result_o.changed    = (known_m != known_i);
        end
    end

    assign survivors_o = cnt_q;

endmodule

// File: rtl/option_sequencer.sv
// Scans a line's candidate options through the simplify checker and merges the
// survivors into newly deduced cells.
// Build option: define SEQ_EARLY_EXIT_EN to stop scanning once no deduction remains.
module option_sequencer
    import nonogram_pkg::*;
#(
    parameter int unsigned SIZE        = DefaultSize,
    parameter int unsigned MAX_OPTIONS = DefaultMaxOptions,
    parameter int unsigned ADDR_W      = $clog2(MAX_OPTIONS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_options,
    input  logic [SIZE-1:0]   assigned_in,
    input  logic [SIZE-1:0]   known_in,
    output logic [ADDR_W-1:0] opt_addr,
    input  logic [SIZE-1:0]   opt_data,
    output logic              simp_valid_in,
    output logic [SIZE-1:0]   simp_assigned,
    output logic [SIZE-1:0]   simp_known,
    output logic [SIZE-1:0]   simp_option,
    input  logic              simp_valid,
    input  logic              simp_contradict,
    output logic              busy,
    output logic              done,
    output logic [SIZE-1:0]   assigned_out,
    output logic [SIZE-1:0]   known_out,
    output logic              contradict,
    output logic              changed,
    output logic [ADDR_W:0]   survivors
);

`ifdef SEQ_EARLY_EXIT_EN
    localparam bit EarlyExitEn = 1'b1;
`else
    localparam bit EarlyExitEn = 1'b0;
`endif

    localparam logic [ADDR_W:0] MaxOpts = (ADDR_W + 1)'(MAX_OPTIONS);

    seq_state_t        state_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   num_q;
    logic [ADDR_W-1:0] opt_addr_q;
    logic              simp_valid_in_q;
    logic [SIZE-1:0]   simp_assigned_q;
    logic [SIZE-1:0]   simp_known_q;
    logic [SIZE-1:0]   simp_option_q;
    logic              busy_q;
    logic              done_q;
    line_result_t      res_q;

    logic              start_ok;
    logic              acc_en;
    logic              acc_saturated;
    logic              early_exit;
    logic [ADDR_W:0]   num_clamped;
    logic [ADDR_W:0]   idx_inc;
    line_result_t      acc_result;

    assign start_ok    = (state_q == IDLE) && start;
    assign acc_en      = (state_q == WAIT) && simp_valid && !simp_contradict;
    assign early_exit  = EarlyExitEn && acc_en && acc_saturated;
    assign num_clamped = (num_options > MaxOpts) ? MaxOpts : num_options;
    assign idx_inc     = idx_q + 1'b1;

    option_accumulator #(
        .SIZE  (SIZE),
        .CNT_W (ADDR_W + 1)
    ) u_acc (
        .clk_i       (clk),
        .rst_ni      (rst),
        .clear_i     (start_ok),
        .acc_en_i    (acc_en),
        .option_i    (simp_option_q),
        .assigned_i  (simp_assigned_q),
        .known_i     (simp_known_q),
        .survivors_o (survivors),
        .saturated_o (acc_saturated),
        .result_o    (acc_result)
    );

    // Sequencer FSM with registered simplify-side and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            num_q           <= '0;
            opt_addr_q      <= '0;
            simp_valid_in_q <= 1'b0;
            simp_assigned_q <= '0;
            simp_known_q    <= '0;
            simp_option_q   <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            res_q           <= '0;
        end else begin
            done_q          <= 1'b0;
            simp_valid_in_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        simp_assigned_q <= assigned_in;
                        simp_known_q    <= known_in;
                        num_q           <= num_clamped;
                        idx_q           <= '0;
                        opt_addr_q      <= '0;
                        busy_q          <= 1'b1;
                        res_q           <= '0;
                        state_q         <= (num_clamped == '0) ? FINISH : FETCH;
                    end
                end
                FETCH: state_q <= READ;
                READ: begin
                    simp_option_q   <= opt_data;
                    simp_valid_in_q <= 1'b1;
                    state_q         <= ISSUE;
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (simp_valid) begin
                        idx_q <= idx_inc;
                        if ((idx_inc == num_q) || early_exit) begin
                            state_q <= FINISH;
                        end else begin
                            // Address moves on entry to FETCH so data lands in READ.
                            opt_addr_q <= idx_inc[ADDR_W-1:0];
                            state_q    <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    res_q   <= acc_result;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign opt_addr      = opt_addr_q;
    assign simp_valid_in = simp_valid_in_q;
    assign simp_assigned = simp_assigned_q;
    assign simp_known    = simp_known_q;
    assign simp_option   = simp_option_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign assigned_out  = res_q.assigned;
    assign known_out     = res_q.known;
    assign contradict    = res_q.contradict;
    assign changed       = res_q.changed;

endmodule
